// File: rtl/axi_tx_fifo_channel_if.sv
// Bus side of the transmit FIFO channel: VALID/READY handshake and data.
// With AXI_TX_LAST_EN defined, the bus also carries xLAST.
interface axi_tx_fifo_channel_if #(
    parameter int WIDTH = 8
);
    logic             VALID;
    logic             READY;
    logic [WIDTH-1:0] xDATA;
`ifdef AXI_TX_LAST_EN
    logic             xLAST;

    modport master (output VALID, output xDATA, output xLAST, input READY);
    modport slave  (input VALID, input xDATA, input xLAST, output READY);
`else
    modport master (output VALID, output xDATA, input READY);
    modport slave  (input VALID, input xDATA, output READY);
`endif
endinterface

// File: rtl/axi_tx_fifo_channel.sv
// DEPTH-entry in-order transmit buffer feeding one VALID/READY channel; bus outputs come from registered state only.
// Optional macro AXI_TX_LAST_EN adds tx_last/xLAST storage and the burst_done pulse.
module axi_tx_fifo_channel #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_tx_fifo_channel_if.master bus,
    input  logic [WIDTH-1:0]      tx_data,
    input  logic                  tx_en,
`ifdef AXI_TX_LAST_EN
    input  logic                  tx_last,
    output logic                  burst_done,
`endif
    output logic                  tx_hold,
    output logic [LW-1:0]         level,
    output logic                  tx_idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef AXI_TX_LAST_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ACTIVE,
        OCC_FULL
    } occ_e;

    logic [SW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] count;
    logic [SW-1:0] head;
    logic [SW-1:0] wr_entry;
    logic          valid;
    logic          push;
    logic          pop;
    occ_e          occ;

    always_comb begin
        occ = OCC_ACTIVE;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == FULL_CNT) begin
            occ = OCC_FULL;
        end
    end

    // Full blocks the push even when a pop happens in the same cycle: no pass-through.
    assign valid   = (occ != OCC_EMPTY);
    assign tx_hold = (occ == OCC_FULL);
    assign tx_idle = (occ == OCC_EMPTY);
    assign level   = count;
    assign push    = tx_en & ~tx_hold;
    assign pop     = valid & bus.READY;

`ifdef AXI_TX_LAST_EN
    assign wr_entry = {tx_last, tx_data};
`else
    assign wr_entry = tx_data;
`endif

    // NOTE: the reset branch also clears count, so VALID falls the moment ARESETn asserts.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count decide which entries are live.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head      = mem[rd_ptr];
    assign bus.VALID = valid;
    assign bus.xDATA = valid ? head[WIDTH-1:0] : '0;

`ifdef AXI_TX_LAST_EN
    assign bus.xLAST = valid & head[WIDTH];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            burst_done <= 1'b0;
        end else begin
            burst_done <= pop & head[WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_axi_tx_fifo_channel.sv
// Randomised self-checking bench for axi_tx_fifo_channel against a queue model of the buffer.
// Define AXI_TX_LAST_EN for both bench and RTL to cover the LAST feature.
module tb_axi_tx_fifo_channel;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          ACLK;
    logic          ARESETn;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          tx_last;
    logic          tx_hold;
    logic [LW-1:0] level;
    logic          tx_idle;
`ifdef AXI_TX_LAST_EN
    logic          burst_done;
`endif

    axi_tx_fifo_channel_if #(.WIDTH(WIDTH)) bus ();

    axi_tx_fifo_channel #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .bus        (bus),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
`ifdef AXI_TX_LAST_EN
        .tx_last    (tx_last),
        .burst_done (burst_done),
`endif
        .tx_hold    (tx_hold),
        .level      (level),
        .tx_idle    (tx_idle)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] ref_q[$];   // {last, data} in push order
    bit         exp_burst;

    function automatic logic [7:0] m_data();
        return (ref_q.size() != 0) ? ref_q[0][7:0] : 8'h00;
    endfunction

    function automatic logic m_last();
        return (ref_q.size() != 0) ? ref_q[0][8] : 1'b0;
    endfunction

    // One clock: model decisions use the values in place before the edge, outputs are observed 1 unit after.
    task automatic step();
        bit do_push;
        bit do_pop;
        bit pop_last;
        do_pop   = ARESETn && (ref_q.size() != 0) && bus.READY;
        do_push  = ARESETn && tx_en && (ref_q.size() < DEPTH);
        pop_last = do_pop && m_last();
        @(posedge ACLK);
        #1;
        if (!ARESETn) begin
            ref_q.delete();
            exp_burst = 1'b0;
        end else begin
            if (do_pop)  void'(ref_q.pop_front());
            if (do_push) ref_q.push_back({tx_last, tx_data});
            exp_burst = pop_last;
        end
    endtask

    task automatic test_reset();
        ARESETn   = 1'b0;
        tx_en     = 1'b1;
        tx_data   = 8'h77;
        tx_last   = 1'b0;
        bus.READY = 1'b0;
        repeat (2) step();
        checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.VALID); end
        checks++; if (bus.xDATA !== 8'h00) begin errors++; $display("FAIL reset_xdata got %h want 00", bus.xDATA); end
        checks++; if (tx_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", tx_hold); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", tx_idle); end
        tx_en   = 1'b0;
        ARESETn = 1'b1;
        step();
        tx_en   = 1'b1;
        tx_data = 8'h3C;
        #1;
        checks++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL no_same_cycle got %b want 0", bus.VALID); end
        step();
        tx_en = 1'b0;
        checks++; if (bus.VALID !== 1'b1 || bus.xDATA !== 8'h3C) begin
            errors++; $display("FAIL first_push got %b/%h want 1/3c", bus.VALID, bus.xDATA);
        end
        bus.READY = 1'b1;
        step();
        bus.READY = 1'b0;
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL first_drain got %b want 1", tx_idle); end
    endtask

    task automatic test_single_beat();
        bus.READY = 1'b1;
        tx_en     = 1'b1;
        tx_data   = 8'hA5;
        step();
        tx_en = 1'b0;
        checks++; if (bus.VALID !== 1'b1 || bus.xDATA !== 8'hA5 || level !== LW'(1)) begin
            errors++; $display("FAIL single_present got %b/%h/%0d want 1/a5/1", bus.VALID, bus.xDATA, level);
        end
        step();
        checks++; if (bus.VALID !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL single_gone got %b/%0d want 0/0", bus.VALID, level);
        end
    endtask

    task automatic test_backpressure();
        bus.READY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tx_data = 8'(i);
            tx_en   = 1'b1;
            step();
        end
        checks++; if (level !== LW'(4) || tx_hold !== 1'b1) begin
            errors++; $display("FAIL bp_full got level %0d hold %b want 4/1", level, tx_hold);
        end
        checks++; if (ref_q.size() != 4 || ref_q[3][7:0] != 8'h04) begin
            errors++; $display("FAIL bp_model got size %0d want 4", ref_q.size());
        end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (bus.VALID !== 1'b1 || bus.xDATA !== 8'h01 || tx_hold !== 1'b1) begin
                errors++; $display("FAIL bp_stall[%0d] got %b/%h/%b want 1/01/1", k, bus.VALID, bus.xDATA, tx_hold);
            end
        end
    endtask

    task automatic test_drain_refill();
        logic [7:0] exp_seq [5];
        exp_seq   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        bus.READY = 1'b1;   // tx_en=1 with 0x05 still held from backpressure
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.VALID !== 1'b1 || bus.xDATA !== exp_seq[k]) begin
                errors++; $display("FAIL drain[%0d] got %b/%h want 1/%h", k, bus.VALID, bus.xDATA, exp_seq[k]);
            end
            step();
            if (k == 0) begin
                checks++; if (tx_hold !== 1'b0) begin errors++; $display("FAIL drain_hold got %b want 0", tx_hold); end
            end
            if (k == 1) begin
                tx_en = 1'b0;
                checks++; if (level !== LW'(3)) begin errors++; $display("FAIL refill_level got %0d want 3", level); end
            end
        end
        checks++; if (bus.VALID !== 1'b0 || tx_idle !== 1'b1) begin
            errors++; $display("FAIL drain_empty got %b/%b want 0/1", bus.VALID, tx_idle);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        bus.READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tx_data = 8'h10 + 8'(i);
            tx_en   = 1'b1;
            step();
            checks++; if (level !== LW'(1)) begin errors++; $display("FAIL wrap_level[%0d] got %0d want 1", i, level); end
            if (bus.VALID === 1'b1) got.push_back(bus.xDATA);
        end
        tx_en = 1'b0;
        step();
        checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_count got %0d want 10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, got[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_random();
        bit         blocked;
        logic       prev_valid;
        logic       prev_ready;
        logic [7:0] prev_data;
        blocked = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.READY = 1'($urandom_range(0, 1));
            if (!blocked) begin
                tx_en   = ($urandom_range(0, 3) != 0);
                tx_data = 8'($urandom);
                tx_last = 1'($urandom);
            end
            blocked    = tx_en && tx_hold;
            prev_valid = bus.VALID;
            prev_ready = bus.READY;
            prev_data  = bus.xDATA;
            step();
            checks++; if (bus.VALID !== (ref_q.size() != 0) || bus.xDATA !== m_data()) begin
                errors++; $display("FAIL rand_head[%0d] got %b/%h want %b/%h", c, bus.VALID, bus.xDATA, ref_q.size() != 0, m_data());
            end
            checks++; if (level !== LW'(ref_q.size()) || tx_hold !== (ref_q.size() == DEPTH) || tx_idle !== (ref_q.size() == 0)) begin
                errors++; $display("FAIL rand_occ[%0d] got %0d/%b/%b want %0d", c, level, tx_hold, tx_idle, ref_q.size());
            end
            if (prev_valid && !prev_ready) begin
                checks++; if (bus.VALID !== 1'b1 || bus.xDATA !== prev_data) begin
                    errors++; $display("FAIL rand_stable[%0d] got %b/%h want 1/%h", c, bus.VALID, bus.xDATA, prev_data);
                end
            end
`ifdef AXI_TX_LAST_EN
            checks++; if (bus.xLAST !== m_last() || burst_done !== exp_burst) begin
                errors++; $display("FAIL rand_last[%0d] got %b/%b want %b/%b", c, bus.xLAST, burst_done, m_last(), exp_burst);
            end
`endif
        end
        tx_en     = 1'b0;
        bus.READY = 1'b1;
        repeat (DEPTH) step();
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL rand_drain got %b want 1", tx_idle); end
    endtask

    task automatic test_mid_reset();
        bus.READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'h30 + 8'(i);
            tx_en   = 1'b1;
            step();
        end
        tx_en = 1'b0;
        checks++; if (level !== LW'(3)) begin errors++; $display("FAIL mid_fill got %0d want 3", level); end
        ARESETn = 1'b0;
        #1;
        checks++; if (bus.VALID !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL mid_async got %b/%0d want 0/0", bus.VALID, level);
        end
        repeat (2) step();
        ARESETn = 1'b1;
        step();
        checks++; if (level !== '0 || bus.VALID !== 1'b0 || bus.xDATA !== 8'h00) begin
            errors++; $display("FAIL mid_stale got %0d/%b/%h want 0/0/00", level, bus.VALID, bus.xDATA);
        end
`ifdef AXI_TX_LAST_EN
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 3; i++) begin
                tx_data = 8'h20 + 8'(i);
                tx_last = (i == 2);
                tx_en   = 1'b1;
                step();
            end
            tx_en     = 1'b0;
            tx_last   = 1'b0;
            bus.READY = 1'b1;
            for (int k = 0; k < 4; k++) begin
                checks++; if (bus.xLAST !== (bus.VALID === 1'b1 && bus.xDATA === 8'h22)) begin
                    errors++; $display("FAIL last_flag[%0d] got %b data %h", k, bus.xLAST, bus.xDATA);
                end
                step();
                if (burst_done === 1'b1) pulses++;
                checks++; if (burst_done !== (k == 2)) begin
                    errors++; $display("FAIL burst_done[%0d] got %b want %b", k, burst_done, k == 2);
                end
            end
            checks++; if (pulses != 1) begin errors++; $display("FAIL burst_pulses got %0d want 1", pulses); end
        end
`endif
    endtask

    initial begin
        exp_burst = 1'b0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_drain_refill();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_tx_fifo_channel.md
Name: axi_tx_fifo_channel

Overview:
Parametrised transmit side of one AXI-style VALID/READY channel. It replaces the single-beat hold stage with a DEPTH-entry in-order buffer. The data source pushes beats with tx_en/tx_hold. The block presents them on the bus with fully registered VALID and xDATA, and keeps both stable until the receiver asserts READY. There is no combinational path from READY to VALID, xDATA or tx_hold.

Parameters:
WIDTH, 8, bus data width in bits (>=1)
DEPTH, 4, buffer entries (>=2, any integer, wrap handled explicitly)
LW, $clog2(DEPTH+1), derived width of the level output; do not override

Ports:
ACLK  in  1  clock, all state updates on rising edge
ARESETn  in  1  reset, asynchronous, active-low
READY  in  1  receiver ready
VALID  out  1  beat present on bus
xDATA  out  WIDTH  bus data
tx_data  in  WIDTH  staged source data
tx_en  in  1  source push request
tx_hold  out  1  buffer full; source must hold tx_data/tx_en
level  out  LW  number of entries currently buffered (0..DEPTH)
tx_idle  out  1  level==0

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, wr_ptr=0, count=0. Outputs: VALID=0, xDATA=0, tx_hold=0, level=0, tx_idle=1.
- Reset asserted mid-operation discards all buffered beats. VALID drops immediately, without waiting for a clock.
- Push accepted: push = tx_en & ~tx_hold. The entry is written at wr_ptr and wr_ptr advances.
- tx_en while tx_hold=1 is ignored. Nothing is written and the source retries.
- Pop: pop = VALID & READY. rd_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0.
- count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Derived outputs:
  - VALID = (count != 0)
  - xDATA = mem[rd_ptr] when VALID, 0 when empty
  - tx_hold = (count == DEPTH)
  - level = count
  - tx_idle = (count == 0)
  All of these derive only from registered state.
- Latency: a push into an empty buffer appears with VALID=1 on the next cycle. A push is never presented in the same cycle it is accepted.
- Throughput: one beat per cycle sustained when READY=1 and the source pushes every cycle.
- Full: tx_hold=1 blocks the push even when a pop occurs in the same cycle. There is no pass-through at full. tx_hold deasserts the cycle after the first pop.
- Empty with READY=1: no pop, VALID=0.
- READY asserted before VALID is legal. The transfer completes on the first cycle in which both are 1.
- Protocol rules:
  - Once VALID=1, VALID stays 1 and xDATA stays unchanged until a cycle with READY=1.
  - VALID never waits on READY to assert.
  - Beats leave in push order.
- Occupancy states, derived from count:
  - EMPTY (0)
  - ACTIVE (1..DEPTH-1)
  - FULL (DEPTH)
  Transitions follow the count rules above. FULL->EMPTY requires DEPTH pops.

Optional Feature:
Macro: AXI_TX_LAST_EN
- Defined:
  - Adds input tx_last (1) and output xLAST (1).
  - Each entry stores {tx_last, tx_data}, so storage is WIDTH+1 bits.
  - xLAST = stored last bit of the head entry, 0 when empty. It follows the same stability rule as xDATA.
  - Adds output burst_done (1): a one-cycle pulse in the cycle after a pop with xLAST=1.
- Not defined:
  - tx_last, xLAST and burst_done ports are absent.
  - Storage is WIDTH bits.
  - Behaviour is otherwise identical.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4.
1. Reset: hold ARESETn=0 for 2 cycles with tx_en=1 -> VALID=0, xDATA=0x00, tx_hold=0, level=0, tx_idle=1. After release, the first push of 0x3C gives VALID=1, xDATA=0x3C one cycle later.
2. Single beat: READY=1, push 0xA5 for one cycle -> next cycle VALID=1, xDATA=0xA5, level=1. The following cycle VALID=0, level=0.
3. Backpressure: READY=0, source presents 0x01..0x05 on consecutive cycles -> 0x01..0x04 accepted, level=4, tx_hold=1, 0x05 held at the source. VALID stays 1 and xDATA stays 0x01 for 10 stalled cycles.
4. Drain and refill: continue from 3 with READY=1 -> xDATA=0x01,0x02,0x03,0x04,0x05 on consecutive cycles. tx_hold=0 the cycle after the first pop, and 0x05 is accepted then.
5. Wrap plus simultaneous push/pop: READY=1, push 0x10..0x19 every cycle -> level stays 1 after the first beat. The output order is 0x10..0x19 with both pointers wrapping twice. Random READY toggling preserves order with no lost or duplicated beats.
6. Mid-operation reset (and, with AXI_TX_LAST_EN, LAST handling): with level=3, assert ARESETn=0 -> VALID=0 asynchronously, and after release level=0 with no stale beat. With AXI_TX_LAST_EN, push 0x20,0x21,0x22 with tx_last=0,0,1 -> xLAST=1 only with 0x22, and burst_done pulses once the cycle after its pop.
